// File: rtl/draw_pkg.sv
// Shared drawing definitions: screen geometry, colour constants and fill FSM state encoding.
package draw_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned COL_W    = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDraw = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [COL_W-1:0] BLACK = 3'b000;
    localparam logic [COL_W-1:0] BLUE  = 3'b001;
    localparam logic [COL_W-1:0] GREEN = 3'b010;
    localparam logic [COL_W-1:0] RED   = 3'b100;
    localparam logic [COL_W-1:0] WHITE = 3'b111;

    function automatic logic on_screen(input int unsigned x, input int unsigned y);
        return (x < SCREEN_W) && (y < SCREEN_H);
    endfunction

endpackage

// File: rtl/rect_fill_engine_if.sv
// Command and pixel-stream bundle between the control FSM (master) and the fill engine (slave).
interface rect_fill_engine_if #(
    parameter int unsigned X_W   = 10,
    parameter int unsigned Y_W   = 9,
    parameter int unsigned DIM_W = 10,
    parameter int unsigned COL_W = 3
);

    logic             start;
    logic             abort;
    logic [X_W-1:0]   x0;
    logic [Y_W-1:0]   y0;
    logic [DIM_W-1:0] width;
    logic [DIM_W-1:0] height;
    logic [COL_W-1:0] colour_in;

    logic [X_W-1:0]   out_x;
    logic [Y_W-1:0]   out_y;
    logic [COL_W-1:0] out_colour;
    logic             plot;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, x0, y0, width, height, colour_in,
        input  out_x, out_y, out_colour, plot, busy, done
    );

    modport slave (
        input  start, abort, x0, y0, width, height, colour_in,
        output out_x, out_y, out_colour, plot, busy, done
    );

endinterface

// File: rtl/rect_raster_counter.sv
// Row-major dx/dy scan counter; exposes the post-step position so the owner can register it.
module rect_raster_counter #(
    parameter int unsigned DIM_W = 10
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic [DIM_W-1:0] i_width,
    input  logic [DIM_W-1:0] i_height,
    output logic [DIM_W-1:0] o_dx_adv,
    output logic [DIM_W-1:0] o_dy_adv,
    output logic             o_last
);

    logic [DIM_W-1:0] r_dx;
    logic [DIM_W-1:0] r_dy;
    logic             w_row_end;

    assign w_row_end = (r_dx == i_width - DIM_W'(1));
    assign o_last    = w_row_end && (r_dy == i_height - DIM_W'(1));
    assign o_dx_adv  = w_row_end ? '0 : r_dx + DIM_W'(1);
    assign o_dy_adv  = w_row_end ? r_dy + DIM_W'(1) : r_dy;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (i_clear) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (i_step) begin
            r_dx <= o_dx_adv;
            r_dy <= o_dy_adv;
        end
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: one clipped pixel per clock in row-major order, then a one-cycle done.
module rect_fill_engine #(
    parameter int unsigned X_W   = 10,
    parameter int unsigned Y_W   = 9,
    parameter int unsigned DIM_W = 10,
    parameter int unsigned COL_W = 3
) (
    input logic               clock,
    input logic               resetn,
    rect_fill_engine_if.slave bus
);

    import draw_pkg::*;

    state_e           r_state;
    state_e           w_state_nxt;

    logic [X_W-1:0]   r_x0;
    logic [Y_W-1:0]   r_y0;
    logic [DIM_W-1:0] r_width;
    logic [DIM_W-1:0] r_height;
    logic [COL_W-1:0] r_colour;

    logic [X_W-1:0]   r_out_x,      w_out_x_nxt;
    logic [Y_W-1:0]   r_out_y,      w_out_y_nxt;
    logic [COL_W-1:0] r_out_colour, w_out_colour_nxt;
    logic             r_plot,       w_plot_nxt;
    logic             r_busy,       w_busy_nxt;
    logic             r_done,       w_done_nxt;

    logic             w_accept;
    logic             w_zero_size;
    logic             w_step;
    logic             w_last;
    logic [DIM_W-1:0] w_dx_adv;
    logic [DIM_W-1:0] w_dy_adv;
    logic [DIM_W-1:0] w_dx_src;
    logic [DIM_W-1:0] w_dy_src;
    logic [X_W-1:0]   w_base_x;
    logic [Y_W-1:0]   w_base_y;
    logic [COL_W-1:0] w_base_colour;
    logic [X_W:0]     w_sum_x;
    logic [Y_W:0]     w_sum_y;
    logic             w_visible;

    assign w_accept    = (r_state == StIdle) && bus.start && !bus.abort;
    assign w_zero_size = (bus.width == '0) || (bus.height == '0);

    rect_raster_counter #(
        .DIM_W (DIM_W)
    ) u_counter (
        .clock    (clock),
        .resetn   (resetn),
        .i_clear  (w_accept),
        .i_step   (w_step),
        .i_width  (r_width),
        .i_height (r_height),
        .o_dx_adv (w_dx_adv),
        .o_dy_adv (w_dy_adv),
        .o_last   (w_last)
    );

    // On the accept edge the operands are not yet latched, so address from the inputs at (0,0).
    assign w_base_x      = w_accept ? bus.x0 : r_x0;
    assign w_base_y      = w_accept ? bus.y0 : r_y0;
    assign w_base_colour = w_accept ? bus.colour_in : r_colour;
    assign w_dx_src      = w_accept ? '0 : w_dx_adv;
    assign w_dy_src      = w_accept ? '0 : w_dy_adv;

    assign w_sum_x   = {1'b0, w_base_x} + (X_W+1)'(w_dx_src);
    assign w_sum_y   = {1'b0, w_base_y} + (Y_W+1)'(w_dy_src);
    assign w_visible = on_screen(32'(w_sum_x), 32'(w_sum_y));

    always_comb begin
        w_state_nxt      = r_state;
        w_plot_nxt       = 1'b0;
        w_busy_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        w_step           = 1'b0;
        w_out_x_nxt      = r_out_x;
        w_out_y_nxt      = r_out_y;
        w_out_colour_nxt = r_out_colour;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_busy_nxt = 1'b1;
                    if (w_zero_size) begin
                        w_state_nxt = StDone;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt      = StDraw;
                        w_plot_nxt       = w_visible;
                        w_out_x_nxt      = w_sum_x[X_W-1:0];
                        w_out_y_nxt      = w_sum_y[Y_W-1:0];
                        w_out_colour_nxt = w_base_colour;
                    end
                end
            end
            StDraw: begin
                // Abort outranks completion, so the last pixel can still be cancelled.
                if (bus.abort) begin
                    w_state_nxt = StIdle;
                end else if (w_last) begin
                    w_state_nxt = StDone;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_step           = 1'b1;
                    w_busy_nxt       = 1'b1;
                    w_plot_nxt       = w_visible;
                    w_out_x_nxt      = w_sum_x[X_W-1:0];
                    w_out_y_nxt      = w_sum_y[Y_W-1:0];
                    w_out_colour_nxt = w_base_colour;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= StIdle;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_out_colour <= '0;
            r_plot       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_out_x      <= w_out_x_nxt;
            r_out_y      <= w_out_y_nxt;
            r_out_colour <= w_out_colour_nxt;
            r_plot       <= w_plot_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_x0     <= '0;
            r_y0     <= '0;
            r_width  <= '0;
            r_height <= '0;
            r_colour <= '0;
        end else if (w_accept) begin
            r_x0     <= bus.x0;
            r_y0     <= bus.y0;
            r_width  <= bus.width;
            r_height <= bus.height;
            r_colour <= bus.colour_in;
        end
    end

    assign bus.out_x      = r_out_x;
    assign bus.out_y      = r_out_y;
    assign bus.out_colour = r_out_colour;
    assign bus.plot       = r_plot;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: table of directed fills, corner sequences, random fills.
module tb_rect_fill_engine;

    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 9;
    localparam int unsigned DIM_W = 10;
    localparam int unsigned COL_W = 3;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    rect_fill_engine_if #(.X_W(X_W), .Y_W(Y_W), .DIM_W(DIM_W), .COL_W(COL_W)) bus ();

    rect_fill_engine #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .DIM_W (DIM_W),
        .COL_W (COL_W)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x0, y0, w, h, col;
        int abort_at;
        bit glitch;
        int exp_plots, exp_scan, exp_dones;
        int fx, fy, lx, ly;
    } vec_t;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_cycle(input string name, input bit ep, input bit eb, input bit ed,
                               input int ex, input int ey, input int ec);
        bit ok;
        n_checks++;
        ok = (bus.plot === ep) && (bus.busy === eb) && (bus.done === ed);
        if (ep) begin
            ok = ok && (bus.out_x === 10'(ex)) && (bus.out_y === 9'(ey))
                    && (bus.out_colour === 3'(ec));
        end
        if (!ok) begin
            n_errs++;
            $display("FAIL %s: got plot=%0b busy=%0b done=%0b xy=(%0d,%0d) col=%0d, expected plot=%0b busy=%0b done=%0b xy=(%0d,%0d) col=%0d",
                     name, bus.plot, bus.busy, bus.done, bus.out_x, bus.out_y, bus.out_colour,
                     ep, eb, ed, ex, ey, ec);
        end
    endtask

    task automatic scramble_ops();
        bus.x0        = 10'($urandom);
        bus.y0        = 9'($urandom);
        bus.width     = 10'($urandom);
        bus.height    = 10'($urandom);
        bus.colour_in = 3'($urandom);
    endtask

    // Called at a negedge; start is driven immediately so consecutive calls run back to back.
    task automatic run_cmd(input vec_t v, input int reset_at, output int plots, output int scan,
                           output int fx, output int fy, output int lx, output int ly,
                           output int dones);
        int n;
        plots = 0; scan = 0; dones = 0;
        fx = -1; fy = -1; lx = -1; ly = -1;
        bus.start     = 1'b1;
        bus.abort     = 1'b0;
        bus.x0        = 10'(v.x0);
        bus.y0        = 9'(v.y0);
        bus.width     = 10'(v.w);
        bus.height    = 10'(v.h);
        bus.colour_in = 3'(v.col);
        @(negedge clock);
        bus.start = 1'b0;
        scramble_ops();
        n = (v.w == 0 || v.h == 0) ? 0 : v.w * v.h;
        for (int k = 0; k < n; k++) begin
            int x;
            int y;
            bit p;
            x = v.x0 + k % v.w;
            y = v.y0 + k / v.w;
            p = (x < 640) && (y < 480);
            check_cycle($sformatf("pixel%0d", k), p, 1'b1, 1'b0, x, y, v.col);
            scan++;
            if (bus.plot === 1'b1) begin
                plots++;
                if (fx < 0) begin
                    fx = int'(bus.out_x);
                    fy = int'(bus.out_y);
                end
                lx = int'(bus.out_x);
                ly = int'(bus.out_y);
            end
            bus.start = (v.glitch && k == 1);
            if (bus.start) scramble_ops();
            bus.abort = (k == v.abort_at);
            if (k == reset_at) begin
                #2 resetn = 1'b0;
                #1;
                check_cycle("reset_async_flags", 1'b0, 1'b0, 1'b0, 0, 0, 0);
                check_val("reset_async_x", 32'(bus.out_x), 0);
                check_val("reset_async_y", 32'(bus.out_y), 0);
                check_val("reset_async_col", 32'(bus.out_colour), 0);
                @(negedge clock);
                resetn = 1'b1;
                return;
            end
            @(negedge clock);
            if (k == v.abort_at) begin
                bus.abort = 1'b0;
                check_cycle("after_abort", 1'b0, 1'b0, 1'b0, 0, 0, 0);
                return;
            end
        end
        bus.start = 1'b0;
        check_cycle("done_cycle", 1'b0, 1'b1, 1'b1, 0, 0, 0);
        if (bus.done === 1'b1) dones++;
        @(negedge clock);
        check_cycle("idle_after_done", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int plots, scan, fx, fy, lx, ly, dones;
        vec_t v;

        vecs[0] = '{152, 226, 80, 50, 2, -1, 1'b1, 4000, 4000, 1, 152, 226, 231, 275};
        vecs[1] = '{10,  20,  3,  2,  5, -1, 1'b0, 6,    6,    1, 10,  20,  12,  21};
        vecs[2] = '{630, 475, 20, 10, 7, -1, 1'b0, 50,   200,  1, 630, 475, 639, 479};
        vecs[3] = '{0,   0,   0,  50, 1, -1, 1'b0, 0,    0,    1, -1,  -1,  -1,  -1};
        vecs[4] = '{100, 100, 30, 10, 4, 100, 1'b0, 101, 101,  0, 100, 100, 110, 103};
        vecs[5] = '{5,   5,   2,  2,  6, -1, 1'b0, 4,    4,    1, 5,   5,   6,   6};

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.width = '0; bus.height = '0; bus.colour_in = '0;

        #12;
        check_cycle("reset_flags", 1'b0, 1'b0, 1'b0, 0, 0, 0);
        check_val("reset_x", 32'(bus.out_x), 0);
        check_val("reset_y", 32'(bus.out_y), 0);
        check_val("reset_col", 32'(bus.out_colour), 0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i], -1, plots, scan, fx, fy, lx, ly, dones);
            check_val($sformatf("vec%0d_plots", i), 32'(plots), 32'(vecs[i].exp_plots));
            check_val($sformatf("vec%0d_scan", i), 32'(scan), 32'(vecs[i].exp_scan));
            check_val($sformatf("vec%0d_dones", i), 32'(dones), 32'(vecs[i].exp_dones));
            if (vecs[i].exp_plots > 0) begin
                check_val($sformatf("vec%0d_first_x", i), 32'(fx), 32'(vecs[i].fx));
                check_val($sformatf("vec%0d_first_y", i), 32'(fy), 32'(vecs[i].fy));
                check_val($sformatf("vec%0d_last_x", i), 32'(lx), 32'(vecs[i].lx));
                check_val($sformatf("vec%0d_last_y", i), 32'(ly), 32'(vecs[i].ly));
            end
        end

        // Start and abort together in IDLE: the command must be refused.
        bus.start = 1'b1; bus.abort = 1'b1;
        bus.x0 = 10'd50; bus.y0 = 9'd50; bus.width = 10'd4; bus.height = 10'd4;
        bus.colour_in = 3'd3;
        @(negedge clock);
        bus.start = 1'b0; bus.abort = 1'b0;
        check_cycle("start_abort_refused", 1'b0, 1'b0, 1'b0, 0, 0, 0);
        @(negedge clock);
        check_cycle("start_abort_still_idle", 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Reset in the middle of a fill, then a single-pixel command.
        v = vecs[0];
        v.glitch = 1'b0;
        run_cmd(v, 37, plots, scan, fx, fy, lx, ly, dones);
        check_val("midreset_dones", 32'(dones), 0);
        check_cycle("midreset_idle", 1'b0, 1'b0, 1'b0, 0, 0, 0);
        v = '{3, 4, 1, 1, 1, -1, 1'b0, 1, 1, 1, 3, 4, 3, 4};
        run_cmd(v, -1, plots, scan, fx, fy, lx, ly, dones);
        check_val("one_pixel_plots", 32'(plots), 1);
        check_val("one_pixel_dones", 32'(dones), 1);
        check_val("one_pixel_x", 32'(fx), 3);
        check_val("one_pixel_y", 32'(fy), 4);

        // Random fills against a plain count of on-screen pixels.
        for (int r = 0; r < 25; r++) begin
            int model_plots;
            v.x0 = int'($urandom_range(0, 700));
            v.y0 = int'($urandom_range(0, 511));
            v.w = int'($urandom_range(0, 12));
            v.h = int'($urandom_range(0, 8));
            v.col = int'($urandom_range(0, 7));
            v.abort_at = -1;
            v.glitch = 1'($urandom);
            model_plots = 0;
            for (int yy = 0; yy < v.h; yy++) begin
                for (int xx = 0; xx < v.w; xx++) begin
                    if (v.x0 + xx < 640 && v.y0 + yy < 480) model_plots++;
                end
            end
            run_cmd(v, -1, plots, scan, fx, fy, lx, ly, dones);
            check_val($sformatf("rand%0d_plots", r), 32'(plots), 32'(model_plots));
            check_val($sformatf("rand%0d_dones", r), 32'(dones), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Pixel-stream generator that sits between the block-completion control FSM and `vga_adapter`. Accepts one rectangle command (origin, width, height, colour) per start/done handshake and emits one pixel per clock in row-major order as `out_x`/`out_y`/`out_colour`/`plot`, driving the adapter's `x`/`y`/`colour`/`plot` directly. Pixels outside the 640x480 screen are clipped. A one-cycle `done` pulse steps the upstream FSM to its next command.

## Interface
- `X_W`, 10, x coordinate width
- `Y_W`, 9, y coordinate width
- `DIM_W`, 10, width/height operand width
- `COL_W`, 3, colour width (1 bit per channel)
- `clock`  in  1  system clock (CLOCK_50)
- `resetn`  in  1  reset; asynchronous, active-low
- `start`  in  1  command strobe; sampled only in IDLE
- `abort`  in  1  synchronous cancel of the current fill
- `x0`  in  X_W  rectangle left edge
- `y0`  in  Y_W  rectangle top edge
- `width`  in  DIM_W  pixels per row
- `height`  in  DIM_W  row count
- `colour_in`  in  COL_W  fill colour
- `out_x`  out  X_W  pixel x
- `out_y`  out  Y_W  pixel y
- `out_colour`  out  COL_W  pixel colour
- `plot`  out  1  write strobe for current pixel
- `busy`  out  1  high from the accepted start through the DONE cycle
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: `start`=1 latches x0, y0, width, height, colour_in; clears the dx/dy counters; goes to DRAW. If width==0 or height==0, goes to DONE instead and emits no pixels.
- DRAW: each cycle presents pixel (x0+dx, y0+dy). dx increments; at dx==width-1, dx wraps to 0 and dy increments. On dx==width-1 && dy==height-1, goes to DONE.
- Clipping: sum computed at X_W+1 / Y_W+1 bits; plot=0 if x>=640 or y>=480. The scan still advances, so cycle count is independent of clipping.
- DONE: done=1, plot=0, busy=1; next state is IDLE.
- `abort`=1 in DRAW or DONE: next state is IDLE, no done pulse, plot=0 from the next cycle. Abort has priority over completion.
- `start` in DRAW/DONE is ignored and not queued. Input changes after acceptance do not affect the fill in progress.
- `start` and `abort` in the same IDLE cycle: abort wins, command is not accepted.

## Timing
- All outputs registered. Reset values: out_x=0, out_y=0, out_colour=0, plot=0, busy=0, done=0, state=IDLE.
- Start accepted at edge N. First pixel valid (plot=1) during cycle N+1. Pixel k (0-based, row-major) appears during cycle N+1+k.
- Last pixel during cycle N+W*H. done=1 during cycle N+W*H+1. Start is accepted again at the following edge.
- Zero-size command: done=1 during cycle N+1.
- Throughput: W*H+2 cycles per command, back to back.
- resetn low mid-fill: outputs go to their reset values immediately (asynchronous), no done, and the command is lost.

## Structure
- Shared package `draw_pkg`: SCREEN_W=640, SCREEN_H=480, COL_W, the state encoding (IDLE/DRAW/DONE), and colour constants (GREEN=3'b010).
- Sub-module `rect_raster_counter`: dx/dy counters with a `last` flag and clear/step inputs. The FSM, address add, and clipping stay in the top.
- Target size is about 150–250 lines total.

## Test plan
- Reset then start with x0=152, y0=226, W=80, H=50, colour 3'b010 -> 4000 plot cycles; first pixel (152,226), last pixel (231,275); done exactly once, at cycle N+4001.
- W=3, H=2 at (10,20) -> pixel sequence (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), then done.
- Clip: x0=630, y0=475, W=20, H=10 -> 200 scan cycles with plot=1 only for x≤639 and y≤479 (50 pixels); done at N+201.
- W=0, H=50 -> no plot; done during cycle N+1; busy high for 1 cycle.
- Start pulsed during DRAW with different operands -> ignored, first fill completes unchanged. Abort at pixel 100 -> plot low next cycle, no done, new start accepted.
- resetn asserted mid-fill at pixel 37 -> all outputs 0 immediately. After release, a new W=1, H=1 command yields one pixel, then done.
